// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the fetch bus interface
package cpu_pkg;

  localparam int BUS_ADDR_W = 30;
  localparam int BUS_DATA_W = 32;

  // addi x0, x0, 0
  localparam logic [31:0] ISA_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE   = 2'd0,
    IF_REQ    = 2'd1,
    IF_ACCESS = 2'd2,
    IF_STALL  = 2'd3
  } if_bus_state_t;

endpackage

// File: rtl/if_bus_if.sv
// rtl/if_bus_if.sv - instruction-fetch bus interface feeding the IF pipeline register
module if_bus_if
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = BUS_ADDR_W,
  parameter int                DATA_W   = BUS_DATA_W,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(ISA_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as,
  output logic              bus_rw,
  input  logic              bus_rdy,
  input  logic [DATA_W-1:0] bus_rd_data
);

  if_bus_state_t     state;
  logic              first_q;
  logic              discard_q;
  logic [DATA_W-1:0] data_q;
  logic              discard_now;

  // A flush arriving in the rdy cycle itself must still kill the fetched word.
  assign discard_now = discard_q | flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IF_IDLE;
      bus_addr  <= '0;
      first_q   <= 1'b0;
      discard_q <= 1'b0;
      data_q    <= NOP_WORD;
    end else begin
      case (state)
        IF_IDLE: begin
          if (req && !flush) begin
            bus_addr <= addr;
            state    <= IF_REQ;
          end
        end
        IF_REQ: begin
          if (flush) begin
            state <= IF_IDLE;
          end else if (bus_grant) begin
            first_q <= 1'b1;
            state   <= IF_ACCESS;
          end
        end
        IF_ACCESS: begin
          first_q <= 1'b0;
          if (bus_rdy) begin
            data_q    <= discard_now ? NOP_WORD : bus_rd_data;
            discard_q <= 1'b0;
            state     <= stall ? IF_STALL : IF_IDLE;
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        IF_STALL: begin
          if (flush) begin
            data_q <= NOP_WORD;
          end
          if (!stall) begin
            state <= IF_IDLE;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

  assign bus_req = (state == IF_REQ) || (state == IF_ACCESS);
  assign bus_as  = (state == IF_ACCESS) && first_q;
  assign bus_rw  = 1'b1;

  // Bypass so the IF register can sample the word on the same edge it arrives.
  assign rd_data = ((state == IF_ACCESS) && bus_rdy && !discard_now) ? bus_rd_data : data_q;

  assign busy = ((state == IF_IDLE) && req && !flush)
             || ((state == IF_REQ) && !flush)
             || ((state == IF_ACCESS) && !bus_rdy);

endmodule

// File: tb/tb_if_bus_if.sv
// tb/tb_if_bus_if.sv - directed self-checking bench for if_bus_if
module tb_if_bus_if;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, req, bus_grant, bus_rdy;
  logic [29:0] addr;
  logic [31:0] bus_rd_data;
  logic [31:0] rd_data;
  logic        busy, bus_req, bus_as, bus_rw;
  logic [29:0] bus_addr;

  int vectors = 0;
  int miscompares = 0;

  if_bus_if dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .req(req), .addr(addr),
    .rd_data(rd_data), .busy(busy), .bus_req(bus_req), .bus_grant(bus_grant),
    .bus_addr(bus_addr), .bus_as(bus_as), .bus_rw(bus_rw), .bus_rdy(bus_rdy),
    .bus_rd_data(bus_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; req = 1'b0; addr = '0;
    bus_grant = 1'b0; bus_rdy = 1'b0; bus_rd_data = '0;
    tick(); tick();
    settle();
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_as", 32'(bus_as), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_rd_data", rd_data, NOP);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bus_rw", 32'(bus_rw), 32'd1);
    rst = 1'b0;
    tick();

    // zero-wait fetch
    req = 1'b1; addr = 30'h10; settle();
    check("t1_c0_busy", 32'(busy), 32'd1);
    check("t1_c0_bus_req", 32'(bus_req), 32'd0);
    tick();
    bus_grant = 1'b1; settle();
    check("t1_c1_bus_req", 32'(bus_req), 32'd1);
    check("t1_c1_busy", 32'(busy), 32'd1);
    check("t1_c1_bus_as", 32'(bus_as), 32'd0);
    check("t1_c1_bus_addr", 32'(bus_addr), 32'h10);
    tick();
    bus_grant = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'hDEADBEEF; req = 1'b0; settle();
    check("t1_c2_bus_as", 32'(bus_as), 32'd1);
    check("t1_c2_rd_data", rd_data, 32'hDEADBEEF);
    check("t1_c2_busy", 32'(busy), 32'd0);
    tick();
    bus_rdy = 1'b0; bus_rd_data = 32'h0; settle();
    check("t1_c3_bus_req", 32'(bus_req), 32'd0);
    check("t1_c3_rd_data", rd_data, 32'hDEADBEEF);
    check("t1_c3_bus_as", 32'(bus_as), 32'd0);

    // delayed grant, two wait states, addr toggling
    req = 1'b1; addr = 30'h10;
    tick();
    for (int i = 0; i < 3; i++) begin
      addr = 30'h20 + 30'(i); settle();
      check("t2_req_busy", 32'(busy), 32'd1);
      check("t2_req_bus_addr", 32'(bus_addr), 32'h10);
      tick();
    end
    bus_grant = 1'b1; settle();
    check("t2_grant_bus_req", 32'(bus_req), 32'd1);
    tick();
    bus_grant = 1'b0; addr = 30'h3F; settle();
    check("t2_as", 32'(bus_as), 32'd1);
    check("t2_w1_busy", 32'(busy), 32'd1);
    tick();
    settle();
    check("t2_w2_as", 32'(bus_as), 32'd0);
    check("t2_w2_busy", 32'(busy), 32'd1);
    check("t2_w2_bus_addr", 32'(bus_addr), 32'h10);
    tick();
    bus_rdy = 1'b1; bus_rd_data = 32'hA5A5A5A5; req = 1'b0; settle();
    check("t2_rdy_rd_data", rd_data, 32'hA5A5A5A5);
    check("t2_rdy_busy", 32'(busy), 32'd0);
    tick();
    bus_rdy = 1'b0; settle();
    check("t2_done_bus_req", 32'(bus_req), 32'd0);

    // flush while in REQ, then a stray grant
    req = 1'b1; addr = 30'h44;
    tick();
    flush = 1'b1; req = 1'b0; settle();
    check("t3_flush_busy", 32'(busy), 32'd0);
    check("t3_flush_bus_req", 32'(bus_req), 32'd1);
    tick();
    flush = 1'b0; bus_grant = 1'b1; settle();
    check("t3_after_bus_req", 32'(bus_req), 32'd0);
    check("t3_after_bus_as", 32'(bus_as), 32'd0);
    tick();
    settle();
    check("t3_stray_bus_req", 32'(bus_req), 32'd0);
    check("t3_stray_bus_as", 32'(bus_as), 32'd0);
    bus_grant = 1'b0;

    // flush in first ACCESS cycle, rdy two cycles later
    req = 1'b1; addr = 30'h50;
    tick();
    bus_grant = 1'b1; req = 1'b0;
    tick();
    bus_grant = 1'b0; flush = 1'b1; settle();
    check("t4_as", 32'(bus_as), 32'd1);
    check("t4_flush_busy", 32'(busy), 32'd1);
    tick();
    flush = 1'b0; settle();
    check("t4_hold_bus_req", 32'(bus_req), 32'd1);
    tick();
    bus_rdy = 1'b1; bus_rd_data = 32'h12345678; settle();
    check("t4_rdy_bus_req", 32'(bus_req), 32'd1);
    check("t4_rdy_no_bypass", rd_data, 32'hA5A5A5A5);
    tick();
    bus_rdy = 1'b0; settle();
    check("t4_nop", rd_data, NOP);
    check("t4_bus_req", 32'(bus_req), 32'd0);

    // stall across the rdy cycle
    req = 1'b1; addr = 30'h60;
    tick();
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'hCAFEF00D; stall = 1'b1; settle();
    check("t5_rdy_rd_data", rd_data, 32'hCAFEF00D);
    check("t5_rdy_busy", 32'(busy), 32'd0);
    tick();
    bus_rdy = 1'b0; bus_rd_data = 32'h0; addr = 30'h64;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t5_stall_rd_data", rd_data, 32'hCAFEF00D);
      check("t5_stall_busy", 32'(busy), 32'd0);
      check("t5_stall_bus_req", 32'(bus_req), 32'd0);
      tick();
    end
    stall = 1'b0;
    tick();
    settle();
    check("t5_idle_busy", 32'(busy), 32'd1);
    tick();
    settle();
    check("t5_next_bus_req", 32'(bus_req), 32'd1);
    check("t5_next_bus_addr", 32'(bus_addr), 32'h64);

    // reset mid-ACCESS
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0; req = 1'b0; settle();
    check("t6_access_as", 32'(bus_as), 32'd1);
    rst = 1'b1;
    tick();
    settle();
    check("t6_rst_bus_req", 32'(bus_req), 32'd0);
    check("t6_rst_rd_data", rd_data, NOP);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_bus_addr", 32'(bus_addr), 32'd0);
    rst = 1'b0;
    tick();

    // flush while stalled replaces held data
    req = 1'b1; addr = 30'h70;
    tick();
    bus_grant = 1'b1; req = 1'b0;
    tick();
    bus_grant = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'h11112222; stall = 1'b1;
    tick();
    bus_rdy = 1'b0; settle();
    check("t7_stall_hold", rd_data, 32'h11112222);
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0; settle();
    check("t7_flush_nop", rd_data, NOP);
    tick();
    settle();
    check("t7_idle_bus_req", 32'(bus_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
